// File: rtl/dec_out_serializer.sv
// Decimated-sample FIFO and MSB-first serializer with bit clock and frame.
// Define DEC_SER_PARITY_EN to append an even-parity bit after the LSB.
module dec_out_serializer #(
  parameter int DATA_W     = 24,
  parameter int SCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_valid,
  input  logic                          ovf_clr,
  output logic                          sdo,
  output logic                          sclk,
  output logic                          frame,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

`ifdef DEC_SER_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam int BIT_W = $clog2(NBITS + 1);
  localparam int HALF  = SCLK_DIV / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;

  logic [NBITS-1:0]  sh_q, sh_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;

  logic sdo_q, sdo_d;
  logic sclk_q, sclk_d;
  logic frame_q, frame_d;
  logic busy_q, busy_d;

  logic              full, pop, push, drop;
  logic              last_tick, last_bit;
  logic [DATA_W-1:0] head;
  logic [NBITS-1:0]  load;

  assign full = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop  = (state_q == S_IDLE) && (level_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push = sample_valid && (!full || pop);
  assign drop = sample_valid && !push;
  assign head = mem_q[rd_q];

`ifdef DEC_SER_PARITY_EN
  assign load = {head, ^head};
`else
  assign load = head;
`endif

  assign last_tick = (div_q == DIV_W'(SCLK_DIV - 1));
  assign last_bit  = (bit_q == BIT_W'(NBITS - 1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= sample_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      div_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_tick && last_bit) state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sh_d  = sh_q;
    div_d = div_q;
    bit_d = bit_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          sh_d  = load;
          div_d = '0;
          bit_d = '0;
        end
      end
      S_SHIFT: begin
        if (last_tick) begin
          div_d = '0;
          bit_d = bit_q + 1'b1;
          sh_d  = {sh_q[NBITS-2:0], 1'b0};
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        sh_d  = sh_q;
        div_d = div_q;
        bit_d = bit_q;
      end
    endcase
  end

  // Outputs are decoded from next state so they register on the same edge.
  always_comb begin
    sdo_d   = 1'b0;
    sclk_d  = 1'b0;
    frame_d = 1'b0;
    busy_d  = (state_d != S_IDLE);
    if (state_d == S_SHIFT) begin
      sdo_d   = sh_d[NBITS-1];
      sclk_d  = (div_d >= DIV_W'(HALF));
      frame_d = (bit_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sdo_q   <= 1'b0;
      sclk_q  <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sdo_q   <= sdo_d;
      sclk_q  <= sclk_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
    end
  end

  assign sdo        = sdo_q;
  assign sclk       = sclk_q;
  assign frame      = frame_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/dec_out_serializer.md
Name: dec_out_serializer

Overview:
- Downstream consumer of the 24-bit decimation-ratio output mux in the DSM decimation filter.
- Captures each decimated sample on a valid strobe and buffers it in a small FIFO.
- Shifts samples out MSB-first on a serial data pin with a bit clock and frame sync, for off-chip capture through the TT output pins.
- Reports FIFO overflow as a sticky flag.

Parameters:
- DATA_W, 24, sample width; matches the mux output width.
- SCLK_DIV, 4, clk cycles per serial bit; must be even and >=2.
- FIFO_DEPTH, 2, sample buffer entries; power of two, >=2.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous active-high reset.
- sample_in  input  DATA_W  selected decimated sample (two's complement) from the ratio mux.
- sample_valid  input  1  one-cycle strobe; sample_in is valid in this cycle.
- ovf_clr  input  1  clears the sticky overflow flag.
- sdo  output  1  serial data, MSB first.
- sclk  output  1  bit clock: low for the first SCLK_DIV/2 cycles of each bit, high for the second half.
- frame  output  1  high for the whole first bit period of each word.
- busy  output  1  high while the FSM is not in IDLE.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; a sample was dropped.

Behaviour:
- Reset: rst sampled at a rising clk edge. Required state after reset:
  - sdo=0, sclk=0, frame=0, busy=0, overflow=0, fifo_level=0.
  - FIFO pointers zeroed, FSM in IDLE.
  - A frame in progress is aborted with no partial completion.
- FIFO push: on sample_valid, if level<FIFO_DEPTH or a pop occurs in the same cycle, write sample_in; otherwise drop the sample and set overflow.
  - Simultaneous push and pop at full: push accepted, level unchanged.
- Overflow flag: stays set until ovf_clr. If ovf_clr and a new drop occur in the same cycle, the set wins.
- FSM states IDLE, SHIFT, GAP:
  - IDLE: if level>0, pop the head into shift register sh, reset bit_cnt=0 and div_cnt=0, go to SHIFT. Otherwise stay.
  - SHIFT:
    - sdo = sh[MSB]; sclk = (div_cnt >= SCLK_DIV/2); frame = (bit_cnt==0).
    - div_cnt counts 0..SCLK_DIV-1 and wraps.
    - On wrap: shift sh left by 1 and increment bit_cnt.
    - After bit NBITS-1 completes, go to GAP. NBITS = DATA_W, or DATA_W+1 when PARITY_EN is defined.
  - GAP: one clk cycle with sdo=0, sclk=0, frame=0, then return to IDLE.
- Word timing:
  - Word period = NBITS*SCLK_DIV + 2 cycles, including the IDLE pop cycle and the GAP cycle.
  - Back-to-back words are allowed whenever the FIFO is non-empty.
- Latency:
  - sample_valid at edge N with FIFO empty and FSM in IDLE: pop at edge N+1.
  - frame and the MSB appear on the outputs from cycle N+1 (registered, valid after edge N+1).
- Registered outputs: sdo, sclk, frame and busy are all registered, with no combinational path from inputs.
- Data handling: sample_in is passed bit-exact; no truncation or sign handling.
- Reset mid-operation: FIFO contents discarded and outputs forced to their reset values on the same edge.

Optional Feature:
- Macro: DEC_SER_PARITY_EN.
- Defined: after the LSB, one extra bit period carries even parity (XOR of all DATA_W bits), so NBITS = DATA_W+1.
- Undefined: no parity bit, NBITS = DATA_W, and no parity logic is present.

Test Plan:
1. Reset then single sample: after rst, sample_in=24'hA5C3F0 with one valid pulse.
   - sdo reproduces 1010_0101_1100_0011_1111_0000, each bit held 4 cycles.
   - frame high for cycles 1-4 only; busy falls after GAP.
   - Total word period 98 cycles.
2. Back-to-back: valid pulses carrying 24'h000001, 24'h800000 and 24'hFFFFFF, spaced 10 cycles apart.
   - All three words are serialized contiguously, each separated by one GAP plus one IDLE cycle.
   - overflow stays 0 and fifo_level peaks at 2.
3. Overflow: 4 valid pulses in consecutive cycles while a word is shifting.
   - Only the first 2 are buffered; overflow=1.
   - An ovf_clr pulse returns overflow to 0.
   - ovf_clr asserted in the same cycle as a drop leaves overflow=1.
4. Full push+pop: FIFO at 2 with sample_valid arriving exactly on the IDLE pop cycle.
   - Sample accepted, fifo_level stays 2, overflow=0.
5. Mid-frame reset: assert rst at bit 10 of a word.
   - Next edge: sdo=0, sclk=0, frame=0, busy=0, fifo_level=0.
   - No residual bits are output afterwards.
6. Parity (DEC_SER_PARITY_EN defined): sample 24'h000007.
   - 25th bit = 1 and the word period is 102 cycles.
   - Sample 24'h000003 gives a 25th bit of 0.
